// File: rtl/axis_vlan_tag_encoder_pkg.sv
// -----------------------------------------------------------------------------
// axis_vlan_tag_encoder_pkg
//   Shared Ethernet bus definitions used by the egress VLAN tag encoder.
//   - vlan_t            : 12-bit 802.1Q VLAN identifier
//   - ETH_TPID_8021Q    : tag protocol identifier for C-tagged frames
//   - vlan_enc_state_t  : per-frame encoder state
//   - vlan_tag_word()   : builds the 32-bit tag word {TPID, PCP, DEI, VID}
// -----------------------------------------------------------------------------
package axis_vlan_tag_encoder_pkg;

    typedef logic [11:0] vlan_t;

    localparam logic [15:0] ETH_TPID_8021Q = 16'h8100;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        TAG,
        BODY,
        DROP
    } vlan_enc_state_t;

    // PCP and DEI are always zero on egress; priority is not remarked here.
    function automatic logic [31:0] vlan_tag_word(input logic [15:0] tpid, input vlan_t vid);
        return {tpid, 3'b000, 1'b0, vid};
    endfunction

endpackage

// File: rtl/axis_vlan_tag_encoder.sv
// -----------------------------------------------------------------------------
// axis_vlan_tag_encoder
//   Per-port egress VLAN tagger on a 32-bit AXI4-Stream path. Each frame is
//   sent untagged (VLAN == native), tagged with an 802.1Q header inserted after
//   the source MAC (trunk port, non-native VLAN) or dropped.
//
// Ports:
//   clk, rst            fabric clock, asynchronous active-high reset
//   rx_*                input stream (tuser = VLAN ID, valid on first beat)
//   port_vlan, is_trunk port configuration, sampled on each frame's first beat
//   tx_*                output stream, single register stage
//                       (tx_tuser = 1 on tlast of a runt tagged frame)
//   dropped_count       saturating count of dropped frames
// -----------------------------------------------------------------------------
module axis_vlan_tag_encoder
    import axis_vlan_tag_encoder_pkg::*;
#(
    parameter logic [15:0] TPID           = ETH_TPID_8021Q,
    parameter int          DROP_CTR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_tvalid,
    output logic                      rx_tready,
    input  logic [31:0]               rx_tdata,
    input  logic [3:0]                rx_tkeep,
    input  logic                      rx_tlast,
    input  logic [11:0]               rx_tuser,
    input  logic [11:0]               port_vlan,
    input  logic                      is_trunk,
    output logic                      tx_tvalid,
    input  logic                      tx_tready,
    output logic [31:0]               tx_tdata,
    output logic [3:0]                tx_tkeep,
    output logic                      tx_tlast,
    output logic                      tx_tuser,
    output logic [DROP_CTR_WIDTH-1:0] dropped_count
);

    localparam logic [DROP_CTR_WIDTH-1:0] DROP_ONE = 1;

    vlan_enc_state_t            state_q, state_d;
    vlan_t                      vlan_q, vlan_d;
    logic [1:0]                 word_cnt_q, word_cnt_d;
    logic [DROP_CTR_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

    logic                       tx_tvalid_q, tx_tvalid_d;
    logic [31:0]                tx_tdata_q, tx_tdata_d;
    logic [3:0]                 tx_tkeep_q, tx_tkeep_d;
    logic                       tx_tlast_q, tx_tlast_d;
    logic                       tx_tuser_q, tx_tuser_d;

    logic                       out_free;
    logic                       ready_st;
    logic                       rx_fire;

    // Output register can take a new beat this cycle.
    assign out_free = !tx_tvalid_q || tx_tready;

    always_comb begin
        case (state_q)
            TAG:     ready_st = 1'b0;   // tag word occupies the output, input waits
            DROP:    ready_st = 1'b1;   // discard at line rate regardless of output
            default: ready_st = out_free;
        endcase
    end

    // Held low throughout reset so nothing is accepted before state is defined.
    assign rx_tready = !rst && ready_st;
    assign rx_fire   = rx_tvalid && rx_tready;

    always_comb begin
        state_d     = state_q;
        vlan_d      = vlan_q;
        word_cnt_d  = word_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        // Output register: drains on tready, otherwise holds its beat.
        tx_tvalid_d = tx_tvalid_q && !tx_tready;
        tx_tdata_d  = tx_tdata_q;
        tx_tkeep_d  = tx_tkeep_q;
        tx_tlast_d  = tx_tlast_q;
        tx_tuser_d  = tx_tuser_q;

        // Forwarding values; only take effect where tx_tvalid_d is set below.
        if (rx_fire) begin
            tx_tdata_d = rx_tdata;
            tx_tkeep_d = rx_tkeep;
            tx_tlast_d = rx_tlast;
            tx_tuser_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    if (rx_tuser == port_vlan) begin
                        tx_tvalid_d = 1'b1;
                        if (!rx_tlast) state_d = BODY;
                    end else if (is_trunk) begin
                        tx_tvalid_d = 1'b1;
                        vlan_d      = rx_tuser;
                        if (rx_tlast) begin
                            tx_tuser_d = 1'b1;          // single-beat runt
                        end else begin
                            state_d    = HDR;
                            word_cnt_d = 2'd1;
                        end
                    end else begin
                        // Dropped: restore the output register contents.
                        tx_tdata_d = tx_tdata_q;
                        tx_tkeep_d = tx_tkeep_q;
                        tx_tlast_d = tx_tlast_q;
                        tx_tuser_d = tx_tuser_q;
                        if (rx_tlast) begin
                            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_ONE;
                        end else begin
                            state_d = DROP;
                        end
                    end
                end
            end
            HDR: begin
                if (rx_fire) begin
                    tx_tvalid_d = 1'b1;
                    word_cnt_d  = word_cnt_q + 2'd1;
                    if (rx_tlast) begin
                        tx_tuser_d = 1'b1;              // frame ended inside the MACs
                        state_d    = IDLE;
                    end else if (word_cnt_q == 2'd2) begin
                        state_d = TAG;                  // bytes 8..11 done: SA complete
                    end
                end
            end
            TAG: begin
                if (out_free) begin
                    tx_tvalid_d = 1'b1;
                    tx_tdata_d  = vlan_tag_word(TPID, vlan_q);
                    tx_tkeep_d  = 4'hF;
                    tx_tlast_d  = 1'b0;
                    tx_tuser_d  = 1'b0;
                    state_d     = BODY;
                end
            end
            BODY: begin
                if (rx_fire) begin
                    tx_tvalid_d = 1'b1;
                    if (rx_tlast) state_d = IDLE;
                end
            end
            DROP: begin
                // Input fire must not disturb the output register here.
                tx_tdata_d = tx_tdata_q;
                tx_tkeep_d = tx_tkeep_q;
                tx_tlast_d = tx_tlast_q;
                tx_tuser_d = tx_tuser_q;
                if (rx_fire && rx_tlast) begin
                    if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_ONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vlan_q      <= '0;
            word_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            tx_tvalid_q <= 1'b0;
            tx_tdata_q  <= '0;
            tx_tkeep_q  <= '0;
            tx_tlast_q  <= 1'b0;
            tx_tuser_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vlan_q      <= vlan_d;
            word_cnt_q  <= word_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            tx_tvalid_q <= tx_tvalid_d;
            tx_tdata_q  <= tx_tdata_d;
            tx_tkeep_q  <= tx_tkeep_d;
            tx_tlast_q  <= tx_tlast_d;
            tx_tuser_q  <= tx_tuser_d;
        end
    end

    assign tx_tvalid     = tx_tvalid_q;
    assign tx_tdata      = tx_tdata_q;
    assign tx_tkeep      = tx_tkeep_q;
    assign tx_tlast      = tx_tlast_q;
    assign tx_tuser      = tx_tuser_q;
    assign dropped_count = drop_cnt_q;

endmodule
